caravel_ascon: RTL and testbench
================================

CARAVEL_ASCON -- requirements
Module: caravel_ascon

Interface
REQ-001 SHALL have parameter K, default 128, meaning the key and tag width in bits.
REQ-002 SHALL have parameter R, default 64, meaning the rate (block) width in bits.
REQ-003 SHALL have parameter A, default 12, meaning the initialisation and finalisation round count.
REQ-004 SHALL have parameter B, default 6, meaning the round count per data block.
REQ-005 SHALL have parameter L, default 40, meaning the associated-data length in bits.
REQ-006 SHALL have parameter Y, default 104, meaning the plaintext/ciphertext length in bits.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-008 SHALL have port rstb, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port key_i, input, 1, serial key bit.
REQ-010 SHALL have port nonce_i, input, 1, serial nonce bit.
REQ-011 SHALL have port ad_i, input, 1, serial associated-data bit.
REQ-012 SHALL have port data_i, input, 1, serial plaintext (encrypt) or ciphertext (decrypt) bit.
REQ-013 SHALL have port start_i, input, 1, level start request.
REQ-014 SHALL have port decrypt_i, input, 1, mode select: 1 = decrypt, 0 = encrypt.
REQ-015 SHALL have port data_o, output, 1, serial ciphertext/plaintext result.
REQ-016 SHALL have port tag_o, output, 1, serial 128-bit tag.
REQ-017 SHALL have port ready_o, output, 1, operation complete.

Function
REQ-018 SHALL implement Ascon-128: IV 0x80400c0600000000; state S = IV||K||N (320 bits); one permutation round per clock (constant addition, 5-bit S-box layer, linear diffusion).
REQ-019 SHALL run the following loading phase after reset: 7-bit load counter from 0 to 127, one count per rising edge; each edge shifts key_i and nonce_i in MSB-first; ad_i shifts only while count < L; data_i shifts only while count < Y.
REQ-020 SHALL ignore all inputs after load completes until start.
REQ-021 SHALL use FSM states LOAD, IDLE, INIT, AD, MSG, FINAL, DONE.
REQ-022 SHALL pass from LOAD to IDLE after 128 loads.
REQ-023 SHALL move from IDLE to INIT when start_i is sampled high; decrypt_i is latched at that edge into an internal flag_dec.
REQ-024 INIT SHALL run A rounds, then XOR 0^192||K into S.
REQ-025 AD SHALL XOR (AD||1||0^23) into S[319:256], run B rounds, then XOR 1 into S[0].
REQ-026 MSG block 1 SHALL use the first 64 data bits.
REQ-027 In MSG block 1, encrypt SHALL compute C1 = S_r ^ P1 and set S_r = C1; decrypt SHALL compute P1 = S_r ^ C1 and set S_r = C1; block 1 is followed by B rounds.
REQ-028 MSG last block SHALL use the remaining 40 bits.
REQ-029 In MSG last block, out = top 40 bits of S_r ^ data; S_r top 40 SHALL be ciphertext; 1 is XORed at rate bit 23; no rounds.
REQ-030 FINAL SHALL XOR K into S[255:128], run A rounds, and produce T = S[127:0] ^ K.
REQ-031 DONE SHALL set ready_o high and hold it until reset.
REQ-032 ready_o SHALL rise no later than 40 edges after start is sampled.
REQ-033 Output shift SHALL present bit i of the Y-bit result on data_o, and bit i of T on tag_o, in the window from edge 2+i after ready_o rises to the next edge (LSB first).
REQ-034 After the last bit, data_o and tag_o SHALL hold their last value.
REQ-035 start_i held high for several cycles SHALL start only one operation; start_i during LOAD SHALL be ignored.

Reset
REQ-036 On rstb low, all registers SHALL clear asynchronously: state = LOAD, counters = 0, ready_o = 0, data_o = 0, tag_o = 0.
REQ-037 Reset mid-operation SHALL abort, and a full reload SHALL be required.

Verification
REQ-038 Encrypt with K=6d4f8bbf60ec05a07b201d4e5b2119ac, N=05885e606e1271b8d47a74c7b297a318, AD=4153434f4e, PT=6173636f6e2d756e6963617373 -> data_o serial result = 18490112f8d5867a830748390b, and tag equals the Ascon-128 reference tag.
REQ-039 Decrypt with the same K/N/AD and CT=18490112f8d5867a830748390b -> data_o = 6173636f6e2d756e6963617373, and tag equals the encrypt tag.
REQ-040 Check loaded registers after 128 loads: key, nonce, associated_data and input_data equal the applied vectors, and AD/data are not corrupted by the extra cycles.
REQ-041 Drop rstb mid-MSG -> ready_o = 0 immediately; reload and start -> correct result.
REQ-042 Hold start_i for 6 cycles -> a single run, ready_o within 40 cycles, and the cycle count is reported.

Source files
------------

// File: rtl/caravel_ascon.sv
// Ascon-128 AEAD core with serial operand loading and serial result/tag output.
// One permutation round per clock; the 320-bit state is updated in place.

module ascon_sbox (
  input  logic [4:0] x,
  output logic [4:0] y
);
  // x[4] is state word x0, x[0] is x4
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  assign y = SBOX[x];
endmodule

module caravel_ascon #(
  parameter int K = 128,
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 6,
  parameter int L = 40,
  parameter int Y = 104
) (
  input  logic clk,
  input  logic rstb,
  input  logic key_i,
  input  logic nonce_i,
  input  logic ad_i,
  input  logic data_i,
  input  logic start_i,
  input  logic decrypt_i,
  output logic data_o,
  output logic tag_o,
  output logic ready_o
);
  localparam int LW = Y - R;
  localparam logic [63:0]  IV       = 64'h80400c0600000000;
  localparam logic [6:0]   L_CNT    = 7'(L);
  localparam logic [6:0]   Y_CNT    = 7'(Y);
  localparam logic [7:0]   K_OUT    = 8'(K);
  localparam logic [7:0]   Y_OUT    = 8'(Y);
  localparam logic [3:0]   A_LAST   = 4'(A - 1);
  localparam logic [3:0]   B_LAST   = 4'(B - 1);
  localparam logic [3:0]   B_N      = 4'(B);
  localparam logic [R-1:0] PAD_LAST = R'(1) << (R - LW - 1);

  typedef enum logic [2:0] {LOAD, IDLE, INIT, AD, MSG, FINAL, DONE} state_t;
  state_t state, state_nx;

  logic [6:0]   load_cnt;
  logic [K-1:0] key_r;
  logic [127:0] nonce_r;
  logic [L-1:0] ad_r;
  logic [Y-1:0] din_r;
  logic         flag_dec;
  logic [319:0] s, rin, rout;
  logic [3:0]   rnd, nr_off, ri;
  logic [7:0]   rc;
  logic [63:0]  a2;
  logic [Y-1:0] res_r;
  logic [K-1:0] tag_r;
  logic         out_arm;
  logic [7:0]   out_cnt;

  logic [63:0][4:0] sb_in, sb_out;
  logic [63:0]      b0, b1, b2, b3, b4;

  // Rate-block combinations for the two message blocks
  logic [R-1:0]  ad_blk, blk1_out, blk1_rate, last_rate;
  logic [LW-1:0] last_out;

  assign ad_blk    = {ad_r, 1'b1, {(R-L-1){1'b0}}};
  assign blk1_out  = s[319:256] ^ din_r[Y-1:LW];
  assign blk1_rate = flag_dec ? din_r[Y-1:LW] : blk1_out;
  assign last_out  = s[319:320-LW] ^ din_r[LW-1:0];
  assign last_rate = {(flag_dec ? din_r[LW-1:0] : last_out), s[319-LW:256]} ^ PAD_LAST;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Round input: block injection folds into the first round of each phase
  always_comb begin
    rin    = s;
    nr_off = 4'(12 - B);
    case (state)
      INIT:  nr_off = 4'(12 - A);
      AD:    if (rnd == '0) rin[319:256] = s[319:256] ^ ad_blk;
      MSG:   if (rnd == '0) rin[319:256] = blk1_rate;
      FINAL: begin
        nr_off = 4'(12 - A);
        if (rnd == '0) rin[255:128] = s[255:128] ^ key_r;
      end
      default: ;
    endcase
    ri = rnd + nr_off;
    rc = {4'hf - ri, ri};
    a2 = rin[191:128] ^ {56'd0, rc};
    for (int j = 0; j < 64; j++)
      sb_in[j] = {rin[256+j], rin[192+j], a2[j], rin[64+j], rin[j]};
  end

  for (genvar j = 0; j < 64; j++) begin : g_col
    ascon_sbox u_sbox (.x(sb_in[j]), .y(sb_out[j]));
  end

  always_comb begin
    for (int j = 0; j < 64; j++) begin
      b0[j] = sb_out[j][4];
      b1[j] = sb_out[j][3];
      b2[j] = sb_out[j][2];
      b3[j] = sb_out[j][1];
      b4[j] = sb_out[j][0];
    end
  end

  assign rout = {b0 ^ rotr(b0, 19) ^ rotr(b0, 28),
                 b1 ^ rotr(b1, 61) ^ rotr(b1, 39),
                 b2 ^ rotr(b2, 1)  ^ rotr(b2, 6),
                 b3 ^ rotr(b3, 10) ^ rotr(b3, 17),
                 b4 ^ rotr(b4, 7)  ^ rotr(b4, 41)};

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_cnt == 7'd127) state_nx = IDLE;
      IDLE:    if (start_i)            state_nx = INIT;
      INIT:    if (rnd == A_LAST)      state_nx = AD;
      AD:      if (rnd == B_LAST)      state_nx = MSG;
      MSG:     if (rnd == B_N)         state_nx = FINAL;
      FINAL:   if (rnd == A_LAST)      state_nx = DONE;
      default:                         state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= LOAD;
    else       state <= state_nx;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      load_cnt <= '0;
      key_r    <= '0;
      nonce_r  <= '0;
      ad_r     <= '0;
      din_r    <= '0;
      flag_dec <= 1'b0;
      s        <= '0;
      rnd      <= '0;
      res_r    <= '0;
      tag_r    <= '0;
      out_arm  <= 1'b0;
      out_cnt  <= '0;
      data_o   <= 1'b0;
      tag_o    <= 1'b0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_nx == DONE);
      case (state)
        LOAD: begin
          load_cnt <= load_cnt + 7'd1;
          key_r    <= {key_r[K-2:0], key_i};
          nonce_r  <= {nonce_r[126:0], nonce_i};
          if (load_cnt < L_CNT) ad_r  <= {ad_r[L-2:0], ad_i};
          if (load_cnt < Y_CNT) din_r <= {din_r[Y-2:0], data_i};
        end
        IDLE: if (start_i) begin
          s        <= {IV, key_r, nonce_r};
          flag_dec <= decrypt_i;
          rnd      <= '0;
        end
        INIT: begin
          rnd <= (rnd == A_LAST) ? '0 : rnd + 4'd1;
          s   <= (rnd == A_LAST) ? rout ^ {192'd0, key_r} : rout;
        end
        AD: begin
          rnd <= (rnd == B_LAST) ? '0 : rnd + 4'd1;
          s   <= (rnd == B_LAST) ? rout ^ 320'd1 : rout;
        end
        MSG: begin
          if (rnd == '0) res_r[Y-1:LW] <= blk1_out;
          // Final partial block: absorb with padding, no rounds
          if (rnd == B_N) begin
            s[319:256]    <= last_rate;
            res_r[LW-1:0] <= last_out;
            rnd           <= '0;
          end else begin
            s   <= rout;
            rnd <= rnd + 4'd1;
          end
        end
        FINAL: begin
          s   <= rout;
          rnd <= (rnd == A_LAST) ? '0 : rnd + 4'd1;
          if (rnd == A_LAST) tag_r <= rout[127:0] ^ key_r;
        end
        DONE: begin
          // One idle edge after ready_o, then LSB-first shift-out
          if (!out_arm) out_arm <= 1'b1;
          else if (out_cnt < K_OUT) begin
            if (out_cnt < Y_OUT) begin
              data_o <= res_r[0];
              res_r  <= res_r >> 1;
            end
            tag_o   <= tag_r[0];
            tag_r   <= tag_r >> 1;
            out_cnt <= out_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_caravel_ascon.sv
// Directed bench for caravel_ascon: serial load, encrypt/decrypt against a
// bitsliced Ascon-128 reference, latency bound, reset behaviour.

module tb_caravel_ascon;
  logic clk = 1'b0, rstb = 1'b0;
  logic key_i = 1'b0, nonce_i = 1'b0, ad_i = 1'b0, data_i = 1'b0;
  logic start_i = 1'b0, decrypt_i = 1'b0;
  logic data_o, tag_o, ready_o;

  int n_tests = 0, n_fail = 0;

  localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD_V  = 40'h4153434f4e;
  localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;

  logic [103:0] m_ct, m_pt;
  logic [127:0] m_tag_enc, m_tag_dec;

  always #5 clk = ~clk;

  caravel_ascon dut (
    .clk(clk), .rstb(rstb), .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i),
    .data_i(data_i), .start_i(start_i), .decrypt_i(decrypt_i),
    .data_o(data_o), .tag_o(tag_o), .ready_o(ready_o)
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] st, input int nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = st;
    for (int r = 12 - nr; r < 12; r++) begin
      x2 ^= 64'(((15 - r) << 4) | r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
      x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
      x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
      x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
      x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  task automatic ascon_model(input logic [103:0] d, input bit dec,
                             output logic [103:0] res, output logic [127:0] tag);
    logic [319:0] st;
    logic [63:0]  r;
    logic [39:0]  o;
    st = {64'h80400c0600000000, KEY, NONCE};
    st = perm(st, 12);
    st[127:0] ^= KEY;
    st[319:256] ^= {AD_V, 1'b1, 23'd0};
    st = perm(st, 6);
    st[0] ^= 1'b1;
    r = st[319:256] ^ d[103:40];
    res[103:40] = r;
    st[319:256] = dec ? d[103:40] : r;
    st = perm(st, 6);
    o = st[319:280] ^ d[39:0];
    res[39:0] = o;
    st[319:280] = dec ? d[39:0] : o;
    st[279] ^= 1'b1;
    st[255:128] ^= KEY;
    st = perm(st, 12);
    tag = st[127:0] ^ KEY;
  endtask

  task automatic do_reset();
    rstb = 1'b0; start_i = 1'b0; decrypt_i = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic load_vec(input logic [103:0] d, input bit poke_start);
    for (int i = 0; i < 128; i++) begin
      key_i   = KEY[127 - i];
      nonce_i = NONCE[127 - i];
      ad_i    = (i < 40)  ? AD_V[39 - i] : 1'($urandom);
      data_i  = (i < 104) ? d[103 - i]   : 1'($urandom);
      start_i = poke_start && (i >= 50) && (i < 60);
      @(posedge clk); #1;
    end
    key_i = 1'($urandom); nonce_i = 1'($urandom);
    ad_i  = 1'($urandom); data_i  = 1'($urandom);
    start_i = 1'b0;
  endtask

  task automatic run_op(input bit dec, input int hold, output int lat, output bit to,
                        output logic [103:0] res, output logic [127:0] tag);
    int  c;
    bit  got;
    c = 0; got = 0; res = '0; tag = '0;
    decrypt_i = dec; start_i = 1'b1;
    while (!got && c <= 60) begin
      @(posedge clk); #1;
      if (c + 1 >= hold) start_i = 1'b0;
      decrypt_i = 1'($urandom);
      if (ready_o) got = 1;
      else c++;
    end
    start_i = 1'b0;
    lat = c; to = !got;
    if (got) begin
      @(posedge clk);
      for (int i = 0; i < 128; i++) begin
        @(posedge clk); #1;
        if (i < 104) res[i] = data_o;
        tag[i] = tag_o;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_tests++; if (data_o  !== 1'b0) begin n_fail++; $display("FAIL reset_data got=%b exp=0", data_o); end
    n_tests++; if (tag_o   !== 1'b0) begin n_fail++; $display("FAIL reset_tag got=%b exp=0", tag_o); end
    rstb = 1'b1;
  endtask

  task automatic test_load();
    load_vec(PT, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    n_tests++; if (dut.key_r !== KEY) begin n_fail++; $display("FAIL load_key got=%h exp=%h", dut.key_r, KEY); end
    n_tests++; if (dut.nonce_r !== NONCE) begin n_fail++; $display("FAIL load_nonce got=%h exp=%h", dut.nonce_r, NONCE); end
    n_tests++; if (dut.ad_r !== AD_V) begin n_fail++; $display("FAIL load_ad got=%h exp=%h", dut.ad_r, AD_V); end
    n_tests++; if (dut.din_r !== PT) begin n_fail++; $display("FAIL load_data got=%h exp=%h", dut.din_r, PT); end
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL start_in_load_ignored ready=%b exp=0", ready_o); end
  endtask

  task automatic test_encrypt();
    int lat; bit to; logic [103:0] res; logic [127:0] tag;
    run_op(1'b0, 1, lat, to, res, tag);
    n_tests++; if (to || lat > 40) begin n_fail++; $display("FAIL enc_latency got=%0d timeout=%0b exp<=40", lat, to); end
    n_tests++; if (res !== CT) begin n_fail++; $display("FAIL enc_ct_vector got=%h exp=%h", res, CT); end
    n_tests++; if (res !== m_ct) begin n_fail++; $display("FAIL enc_ct_model got=%h exp=%h", res, m_ct); end
    n_tests++; if (tag !== m_tag_enc) begin n_fail++; $display("FAIL enc_tag got=%h exp=%h", tag, m_tag_enc); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (data_o !== m_ct[103]) begin n_fail++; $display("FAIL data_hold got=%b exp=%b", data_o, m_ct[103]); end
    n_tests++; if (tag_o !== m_tag_enc[127]) begin n_fail++; $display("FAIL tag_hold got=%b exp=%b", tag_o, m_tag_enc[127]); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_hold got=%b exp=1", ready_o); end
    // Asynchronous clear from DONE, checked between clock edges
    #2 rstb = 1'b0;
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL async_clear_ready got=%b exp=0", ready_o); end
    n_tests++; if (tag_o !== 1'b0) begin n_fail++; $display("FAIL async_clear_tag got=%b exp=0", tag_o); end
    @(posedge clk); #1;
    rstb = 1'b1;
  endtask

  task automatic test_decrypt();
    int lat; bit to; logic [103:0] res; logic [127:0] tag;
    do_reset();
    load_vec(CT, 1'b0);
    run_op(1'b1, 1, lat, to, res, tag);
    n_tests++; if (to || lat > 40) begin n_fail++; $display("FAIL dec_latency got=%0d timeout=%0b exp<=40", lat, to); end
    n_tests++; if (res !== PT) begin n_fail++; $display("FAIL dec_pt_vector got=%h exp=%h", res, PT); end
    n_tests++; if (res !== m_pt) begin n_fail++; $display("FAIL dec_pt_model got=%h exp=%h", res, m_pt); end
    n_tests++; if (tag !== m_tag_dec) begin n_fail++; $display("FAIL dec_tag_model got=%h exp=%h", tag, m_tag_dec); end
    n_tests++; if (tag !== m_tag_enc) begin n_fail++; $display("FAIL dec_tag_vs_enc got=%h exp=%h", tag, m_tag_enc); end
  endtask

  task automatic test_reset_mid_msg();
    int lat; bit to; logic [103:0] res; logic [127:0] tag;
    do_reset();
    load_vec(PT, 1'b0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    rstb = 1'b0;
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL midmsg_ready got=%b exp=0", ready_o); end
    n_tests++; if (data_o !== 1'b0) begin n_fail++; $display("FAIL midmsg_data got=%b exp=0", data_o); end
    @(posedge clk); #1;
    rstb = 1'b1;
    load_vec(PT, 1'b0);
    run_op(1'b0, 1, lat, to, res, tag);
    n_tests++; if (to || lat > 40) begin n_fail++; $display("FAIL midmsg_latency got=%0d timeout=%0b exp<=40", lat, to); end
    n_tests++; if (res !== m_ct) begin n_fail++; $display("FAIL midmsg_ct got=%h exp=%h", res, m_ct); end
    n_tests++; if (tag !== m_tag_enc) begin n_fail++; $display("FAIL midmsg_tag got=%h exp=%h", tag, m_tag_enc); end
  endtask

  task automatic test_start_hold();
    int lat; bit to; logic [103:0] res; logic [127:0] tag;
    do_reset();
    load_vec(PT, 1'b0);
    run_op(1'b0, 6, lat, to, res, tag);
    $display("[TB] start held 6 cycles: ready_o after %0d cycles", lat);
    n_tests++; if (to || lat > 40) begin n_fail++; $display("FAIL hold_latency got=%0d timeout=%0b exp<=40", lat, to); end
    n_tests++; if (res !== m_ct) begin n_fail++; $display("FAIL hold_ct got=%h exp=%h", res, m_ct); end
    n_tests++; if (tag !== m_tag_enc) begin n_fail++; $display("FAIL hold_tag got=%h exp=%h", tag, m_tag_enc); end
    start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start_i = 1'b0;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL hold_single_run ready=%b exp=1", ready_o); end
    n_tests++; if (data_o !== m_ct[103]) begin n_fail++; $display("FAIL hold_single_data got=%b exp=%b", data_o, m_ct[103]); end
  endtask

  initial begin
    ascon_model(PT, 1'b0, m_ct, m_tag_enc);
    ascon_model(CT, 1'b1, m_pt, m_tag_dec);
    test_reset();
    test_load();
    test_encrypt();
    test_decrypt();
    test_reset_mid_msg();
    test_start_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
